pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscvx_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 22 ++
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvx_pkg.sv
// Shared definitions for the pipeline control slice: controller states,
// forwarding-select codes and the default data-memory timeout.
package riscvx_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  // Wait counter must hold MEM_TIMEOUT and is never narrower than 8 bits.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; MEM beats WB, x0 never forwards.
module fwd_unit
  import riscvx_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       regwrite_MEM,
  input  logic       memread_MEM,
  input  logic [4:0] rd_MEM,
  input  logic       regwrite_WB,
  input  logic [4:0] rd_WB,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_MEM && !memread_MEM && (rd_MEM != '0) && (rd_MEM == rs))
      sel = FWD_MEM;
    else if (regwrite_WB && (rd_WB != '0) && (rd_WB == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: data-memory wait/timeout FSM, load-use and branch
// hazards, operand forwarding and a saturating stall-cycle counter.
module pipeline_ctrl
  import riscvx_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic        memread_EX,
  input  logic [4:0]  rd_EX,
  input  logic        branch_taken_EX,
  input  logic        regwrite_MEM,
  input  logic        memread_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ready,
  input  logic        regwrite_WB,
  input  logic [4:0]  rd_WB,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        flush_WB,
  output logic [1:0]  fwdA_sel,
  output logic [1:0]  fwdB_sel,
  output logic        err,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CW = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  ctrl_state_t   state;
  logic [CW-1:0] wait_cnt;
  logic          lu_done;
  logic          in_err, mstall, hold, lu_cond, lu_stall;
  logic [1:0]    fwd_a, fwd_b;

  assign in_err  = (state == ST_ERR);
  assign mstall  = dmem_req_MEM && !dmem_ready && !in_err;
  assign hold    = in_err || mstall;
  assign lu_cond = memread_EX && (rd_EX != '0) &&
                   ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
  // lu_done makes a persisting load-use condition cost only one bubble;
  // a deferred or branch-suppressed hazard leaves it clear so it re-fires later.
  assign lu_stall = lu_cond && !lu_done && !hold && !branch_taken_EX;

  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    fwdA_sel  = fwd_a;
    fwdB_sel  = fwd_b;
    if (reset) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
      flush_WB = 1'b1;
      fwdA_sel = FWD_RF;
      fwdB_sel = FWD_RF;
    end else if (hold) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
      flush_WB  = 1'b1;
    end else if (branch_taken_EX) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
    end else if (lu_stall) begin
      stall_IF = 1'b1;
      stall_ID = 1'b1;
      flush_EX = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
      lu_done      <= 1'b0;
    end else begin
      lu_done <= lu_cond && (lu_done || lu_stall);
      if (stall_IF && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      case (state)
        ST_RUN: begin
          if (dmem_req_MEM && !dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (dmem_ready) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        end
        ST_ERR: state <= ST_ERR;
        default: state <= ST_RUN;
      endcase
    end
  end

  fwd_unit u_fwd_a (
    .rs           (rs1_EX),
    .regwrite_MEM (regwrite_MEM),
    .memread_MEM  (memread_MEM),
    .rd_MEM       (rd_MEM),
    .regwrite_WB  (regwrite_WB),
    .rd_WB        (rd_WB),
    .sel          (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs           (rs2_EX),
    .regwrite_MEM (regwrite_MEM),
    .memread_MEM  (memread_MEM),
    .rd_MEM       (rd_MEM),
    .regwrite_WB  (regwrite_WB),
    .rd_WB        (rd_WB),
    .sel          (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: single-cycle vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic        memread_EX, branch_taken_EX, regwrite_MEM, memread_MEM;
  logic        dmem_req_MEM, dmem_ready, regwrite_WB;
  logic        stall_IF, stall_ID, stall_EX, stall_MEM;
  logic        flush_ID, flush_EX, flush_WB, err;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic [31:0] stall_cycles;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  // {stall IF,ID,EX,MEM, flush ID,EX,WB, fwdA, fwdB}
  localparam logic [10:0] O_RST  = 11'b0000111_0000;
  localparam logic [10:0] O_MS   = 11'b1111001_0000;
  localparam logic [10:0] O_LU   = 11'b1100010_0000;
  localparam logic [10:0] O_BR   = 11'b0000110_0000;
  localparam logic [10:0] O_NONE = 11'b0000000_0000;

  assign outs = {stall_IF, stall_ID, stall_EX, stall_MEM,
                 flush_ID, flush_EX, flush_WB, fwdA_sel, fwdB_sel};

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .memread_EX(memread_EX), .rd_EX(rd_EX), .branch_taken_EX(branch_taken_EX),
    .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM), .rd_MEM(rd_MEM),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_WB(flush_WB),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .err(err), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string      name;
    logic [4:0] r1i, r2i;
    logic       mre;
    logic [4:0] rde;
    logic       br;
    logic [4:0] r1e, r2e;
    logic       rwm, mrm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic       dreq, drdy;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(string n, logic [4:0] r1i, logic [4:0] r2i, logic mre,
                              logic [4:0] rde, logic br, logic [4:0] r1e, logic [4:0] r2e,
                              logic rwm, logic mrm, logic [4:0] rdm, logic rww,
                              logic [4:0] rdw, logic dreq, logic drdy, logic [10:0] exp);
    vec_t v;
    v.name = n; v.r1i = r1i; v.r2i = r2i; v.mre = mre; v.rde = rde; v.br = br;
    v.r1e = r1e; v.r2e = r2e; v.rwm = rwm; v.mrm = mrm; v.rdm = rdm;
    v.rww = rww; v.rdw = rdw; v.dreq = dreq; v.drdy = drdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic clr();
    rs1_ID = '0; rs2_ID = '0; rs1_EX = '0; rs2_EX = '0; rd_EX = '0;
    rd_MEM = '0; rd_WB = '0; memread_EX = 0; branch_taken_EX = 0;
    regwrite_MEM = 0; memread_MEM = 0; dmem_req_MEM = 0; dmem_ready = 0;
    regwrite_WB = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    @(negedge clk);
    check("rst_outs", 32'(outs), 32'(O_RST));
    tick();
    reset = 1'b0;
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", stall_cycles, 32'd0);
  endtask

  task automatic apply(vec_t v);
    rs1_ID = v.r1i; rs2_ID = v.r2i; memread_EX = v.mre; rd_EX = v.rde;
    branch_taken_EX = v.br; rs1_EX = v.r1e; rs2_EX = v.r2e;
    regwrite_MEM = v.rwm; memread_MEM = v.mrm; rd_MEM = v.rdm;
    regwrite_WB = v.rww; rd_WB = v.rdw; dmem_req_MEM = v.dreq; dmem_ready = v.drdy;
  endtask

  // Behavioural reference: controller mode, time spent waiting, sticky error,
  // whether the current load-use occurrence already cost its bubble.
  bit          m_waiting, m_errored, m_err, m_lu_served;
  int unsigned m_waited;
  logic [31:0] m_stalls;

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (regwrite_MEM && !memread_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b10;
    if (regwrite_WB && rd_WB != 0 && rd_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic rand_cycle();
    logic [10:0] exp;
    bit lu, ms, lu_fire;
    reset = ($urandom_range(0, 99) < 2);
    rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
    rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
    rd_EX  = 5'($urandom_range(0, 3)); rd_MEM = 5'($urandom_range(0, 3));
    rd_WB  = 5'($urandom_range(0, 3));
    memread_EX = ($urandom_range(0, 1) == 1);
    branch_taken_EX = ($urandom_range(0, 7) == 0);
    regwrite_MEM = ($urandom_range(0, 1) == 1); memread_MEM = ($urandom_range(0, 2) == 0);
    regwrite_WB = ($urandom_range(0, 1) == 1);
    dmem_req_MEM = ($urandom_range(0, 9) < 3); dmem_ready = ($urandom_range(0, 1) == 1);

    lu = memread_EX && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
    ms = dmem_req_MEM && !dmem_ready && !m_errored;
    lu_fire = 0;
    exp = O_NONE;
    if (reset) exp = O_RST;
    else begin
      if (m_errored || ms) exp = O_MS;
      else if (branch_taken_EX) exp = O_BR;
      else if (lu && !m_lu_served) begin exp = O_LU; lu_fire = 1; end
      exp[3:2] = ref_fwd(rs1_EX);
      exp[1:0] = ref_fwd(rs2_EX);
    end
    @(negedge clk);
    check("rnd_outs", 32'(outs), 32'(exp));
    check("rnd_err", 32'(err), 32'(m_err));
    check("rnd_cnt", stall_cycles, m_stalls);
    @(posedge clk);
    if (reset) begin
      m_waiting = 0; m_errored = 0; m_err = 0; m_lu_served = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (exp[10] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      m_lu_served = lu && (m_lu_served || lu_fire);
      if (m_waiting) begin
        if (dmem_ready) m_waiting = 0;
        else begin
          m_waited++;
          if (m_waited == TO) begin m_waiting = 0; m_errored = 1; m_err = 1; end
        end
      end else if (!m_errored && ms) begin
        m_waiting = 1; m_waited = 0;
      end
    end
    #1;
  endtask

  vec_t vecs[$];
  vec_t idle;

  initial begin
    //               name        r1i r2i mre rde br r1e r2e rwm mrm rdm rww rdw dreq drdy exp
    vecs.push_back(mk("idle",      0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  0, 0, 1, O_NONE));
    vecs.push_back(mk("lu_rs2",    1,  5, 1,  5, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_LU));
    vecs.push_back(mk("lu_rs1",    9,  2, 1,  9, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_LU));
    vecs.push_back(mk("lu_x0",     0,  0, 1,  0, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_NONE));
    vecs.push_back(mk("lu_nomr",   5,  0, 0,  5, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_NONE));
    vecs.push_back(mk("branch",    0,  0, 0,  0, 1, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_BR));
    vecs.push_back(mk("br_lu",     3,  0, 1,  3, 1, 0,  0,  0, 0,  0, 0,  0, 0, 0, O_BR));
    vecs.push_back(mk("fwd_mem",   0,  0, 0,  0, 0, 7,  0,  1, 0,  7, 1,  7, 0, 0, 11'b0000000_1000));
    vecs.push_back(mk("fwd_ld_wb", 0,  0, 0,  0, 0, 7,  0,  1, 1,  7, 1,  7, 0, 0, 11'b0000000_0100));
    vecs.push_back(mk("fwd_x0",    0,  0, 0,  0, 0, 0,  0,  1, 0,  0, 1,  0, 0, 0, O_NONE));
    vecs.push_back(mk("fwd_b_wb",  0,  0, 0,  0, 0, 4,  3,  1, 0,  4, 1,  3, 0, 0, 11'b0000000_1001));
    vecs.push_back(mk("fwd_nowb",  0,  0, 0,  0, 0, 0,  3,  0, 0,  0, 0,  3, 0, 0, O_NONE));
    vecs.push_back(mk("mstall",    0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  0, 1, 0, O_MS));
    vecs.push_back(mk("ms_br_lu",  2,  0, 1,  2, 1, 0,  0,  0, 0,  0, 0,  0, 1, 0, O_MS));
    vecs.push_back(mk("req_rdy",   0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  0, 1, 1, O_NONE));
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE);

    do_reset();
    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      tick();
      apply(idle);
      tick();
    end

    // Load-use: one bubble even while the condition persists; one stall cycle counted.
    do_reset();
    memread_EX = 1; rd_EX = 5; rs2_ID = 5;
    @(negedge clk); check("lu_first", 32'(outs), 32'(O_LU));
    tick();
    @(negedge clk); check("lu_held", 32'(outs), 32'(O_NONE));
    tick();
    clr(); tick();
    check("lu_cnt", stall_cycles, 32'd1);

    // Memory wait of three cycles then completion.
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("mw_stall", 32'(outs), 32'(O_MS));
      tick();
    end
    dmem_ready = 1;
    @(negedge clk); check("mw_done", 32'(outs), 32'(O_NONE));
    tick();
    check("mw_cnt", stall_cycles, 32'd3);
    check("mw_err", 32'(err), 32'd0);

    // Timeout into the error state, sticky until reset.
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0;
    for (int i = 0; i <= int'(TO); i++) begin
      @(negedge clk); check("to_stall", 32'(outs), 32'(O_MS));
      tick();
      check("to_err", 32'(err), (i == int'(TO)) ? 32'd1 : 32'd0);
    end
    dmem_req_MEM = 0; dmem_ready = 1; branch_taken_EX = 1;
    @(negedge clk); check("err_outs", 32'(outs), 32'(O_MS));
    tick();
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    @(negedge clk); check("err_clr_outs", 32'(outs), 32'(O_NONE));

    // Branch and load-use deferred behind a memory stall.
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0; branch_taken_EX = 1;
    memread_EX = 1; rd_EX = 6; rs1_ID = 6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check("br_defer", 32'(outs), 32'(O_MS));
      tick();
    end
    dmem_ready = 1;
    @(negedge clk); check("br_release", 32'(outs), 32'(O_BR));
    tick();
    branch_taken_EX = 0; dmem_req_MEM = 0;
    @(negedge clk); check("lu_release", 32'(outs), 32'(O_LU));
    tick();
    clr();

    // Reset in the middle of a wait abandons the access.
    do_reset();
    dmem_req_MEM = 1; dmem_ready = 0;
    tick(); tick();
    reset = 1;
    @(negedge clk); check("rst_wait_outs", 32'(outs), 32'(O_RST));
    tick();
    reset = 0; clr();
    repeat (int'(TO) + 2) tick();
    @(negedge clk); check("rst_wait_outs2", 32'(outs), 32'(O_NONE));
    check("rst_wait_err", 32'(err), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    m_waiting = 0; m_errored = 0; m_err = 0; m_lu_served = 0; m_waited = 0; m_stalls = 0;
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
